// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ITER      = 32;
    localparam logic [5:0]  ITER_LAST = 6'(ITER - 1);

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per enable on unsigned magnitudes.
module muldiv_iter
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            en_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_mag_i,
    input  logic [XLEN-1:0] b_mag_i,
    output logic [63:0]     acc_o,
    output logic [5:0]      cnt_o
);

    // acc_q is {partial product, multiplier} or {remainder, dividend/quotient}
    logic [63:0]     acc_q, acc_d;
    logic [XLEN-1:0] opnd_q;
    logic [5:0]      cnt_q;
    logic [32:0]     sum;
    logic [32:0]     trial;

    always_comb begin
        sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        trial = {acc_q[63:32], acc_q[31]} - {1'b0, opnd_q};
        acc_d = acc_q;
        if (is_div_i) begin
            if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
            else            acc_d = {acc_q[62:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_d = {sum, acc_q[31:1]};
        end else begin
            acc_d = {1'b0, acc_q[63:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            acc_q  <= {32'd0, a_mag_i};
            opnd_q <= b_mag_i;
            cnt_q  <= '0;
        end else if (en_i) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + 6'd1;
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO port.
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | 32 iteration cycles in muldiv_iter
// S_FIX  | sign correction, HI/LO update, done pulse
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            hiwe_i,
    input  logic            lowe_i,
    input  logic [XLEN-1:0] wd_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    md_state_e       state_q;
    md_op_e          op_q;
    logic            sa_q, sb_q, bz_q;
    logic            done_q;
    logic [XLEN-1:0] hi_q, lo_q;

    md_op_e          op_in;
    logic            sgn_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            load, step;
    logic [63:0]     acc;
    logic [5:0]      cnt;
    logic [63:0]     prod;
    logic [XLEN-1:0] res_hi, res_lo;

    assign op_in  = md_op_e'(op_i);
    assign sgn_in = is_signed_op(op_in);
    assign a_mag  = (sgn_in && a_i[31]) ? -a_i : a_i;
    assign b_mag  = (sgn_in && b_i[31]) ? -b_i : b_i;
    assign load   = (state_q == S_IDLE) && start_i && !flush_i;
    assign step   = (state_q == S_CALC) && !flush_i;

    muldiv_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .en_i     (step),
        .is_div_i (is_div_op(op_q)),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .acc_o    (acc),
        .cnt_o    (cnt)
    );

    // Sign flags are latched as zero for unsigned ops, so no op check is needed here.
    always_comb begin
        prod   = (sa_q ^ sb_q) ? -acc : acc;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div_op(op_q)) begin
            res_hi = sa_q ? -acc[63:32] : acc[63:32];
            res_lo = bz_q ? 32'hFFFF_FFFF : ((sa_q ^ sb_q) ? -acc[31:0] : acc[31:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= MD_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        state_q <= S_CALC;
                        op_q    <= op_in;
                        sa_q    <= sgn_in && a_i[31];
                        sb_q    <= sgn_in && b_i[31];
                        bz_q    <= (b_i == '0);
                    end else if (!start_i) begin
                        if (hiwe_i) hi_q <= wd_i;
                        if (lowe_i) lo_q <= wd_i;
                    end
                end
                S_CALC: begin
                    if (flush_i)               state_q <= S_IDLE;
                    else if (cnt == ITER_LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!flush_i) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk, rst, start_i, flush_i, hiwe_i, lowe_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i, wd_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] m_hi, m_lo;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .hiwe_i(hiwe_i), .lowe_i(lowe_i), .wd_i(wd_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  p = sa * sb;
            MD_MULTU: p = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    task automatic mt_write(input logic we_hi, input logic we_lo, input logic [31:0] d);
        @(negedge clk);
        hiwe_i = we_hi; lowe_i = we_lo; wd_i = d;
        @(negedge clk);
        hiwe_i = 1'b0; lowe_i = 1'b0;
        if (we_hi) m_hi = d;
        if (we_lo) m_lo = d;
        chk("mt_hi", hi_o, m_hi);
        chk("mt_lo", lo_o, m_lo);
    endtask

    // Runs one operation; optionally asserts MTHI with the start and a stray start mid-CALC.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic with_mt, input logic restart);
        logic [31:0] eh, el;
        int busy_cnt, done_cnt, done_at, leak;
        model(op, a, b, eh, el);
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        hiwe_i = with_mt; wd_i = 32'h0000_AAAA;
        @(negedge clk);
        start_i = 1'b0; hiwe_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
        busy_cnt = 0; done_cnt = 0; done_at = -1; leak = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin done_cnt++; done_at = c; end
            if (busy_o && (hi_o !== m_hi || lo_o !== m_lo)) leak++;
            start_i = restart && (c == 5);
            if (restart && c == 5) begin
                op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        m_hi = eh; m_lo = el;
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'd33);
        chk({tag, "_no_intermediate"}, 32'(leak), 32'd0);
    endtask

    initial begin
        int dn, bsy;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; hiwe_i = 1'b0; lowe_i = 1'b0;
        op_i = '0; a_i = '0; b_i = '0; wd_i = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst = 1'b1;

        mt_write(1'b1, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b0, 32'h0000_0011);
        mt_write(1'b0, 1'b1, 32'h0000_0022);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_ref_hi", m_hi, 32'hFFFF_FFFE);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        chk("mult_neg_ref_lo", m_lo, 32'hFFFF_FFEB);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu_zero", MD_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("div_zero_neg", MD_DIV, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("start_vs_mthi", MD_DIVU, 32'd1000, 32'd7, 1'b1, 1'b1);

        // Flush mid-CALC: HI/LO untouched, no done.
        mt_write(1'b1, 1'b1, 32'h0000_0011);
        mt_write(1'b0, 1'b1, 32'h0000_0022);
        @(negedge clk);
        start_i = 1'b1; op_i = MD_DIVU; a_i = 32'd12345; b_i = 32'd17;
        @(negedge clk);
        start_i = 1'b0;
        dn = 0;
        for (int c = 0; c < 45; c++) begin
            if (done_o) dn++;
            if (c == 10) chk("flush_busy_low", 32'(busy_o), 32'd0);
            flush_i = (c == 9);
            @(negedge clk);
        end
        flush_i = 1'b0;
        chk("flush_hi", hi_o, 32'h0000_0011);
        chk("flush_lo", lo_o, 32'h0000_0022);
        chk("flush_no_done", 32'(dn), 32'd0);

        // Flush in IDLE cancels a same-cycle start.
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = MD_MULTU; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        bsy = 0; dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_o) bsy++;
            if (done_o) dn++;
            @(negedge clk);
        end
        chk("idle_flush_busy", 32'(bsy), 32'd0);
        chk("idle_flush_done", 32'(dn), 32'd0);
        chk("idle_flush_lo", lo_o, m_lo);

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of CALC.
        mt_write(1'b1, 1'b1, 32'h0000_0055);
        @(negedge clk);
        start_i = 1'b1; op_i = MD_MULTU; a_i = $urandom; b_i = $urandom;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_hi", hi_o, 32'd0);
        chk("async_rst_lo", lo_o, 32'd0);
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_done", 32'(done_o), 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst_multu", MD_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
